tmr_word_voter_monitor: RTL
===========================

Name: tmr_word_voter_monitor

Overview:
- Parametrised multi-bit TMR voter with a one-stage valid/ready output register and per-replica fault tracking.
- Votes three replicated words, flags which replica disagreed and keeps saturating per-replica error counters.
- Excludes a replica that is persistently wrong (degraded mode) and flags the block as failed once correction is no longer possible.
- Sits at the output of triplicated datapaths, ahead of single-copy consumers.

Parameters:
DataWidth, 32, width of each replica word
VoterType, 2, per-bit majority implementation: 0 classical AND/OR, 1 KP mux-based, 2 BN mux-based; any other value is a fatal elaboration error (non-synthesis)
FaultThreshold, 4, consecutive mismatching accepted beats that mark a replica faulty (>=1)
CntWidth, 8, width of each per-replica saturating error counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
a_i  in  DataWidth  replica A
b_i  in  DataWidth  replica B
c_i  in  DataWidth  replica C
valid_i  in  1  replicas valid
ready_o  out  1  input accepted when valid_i & ready_o
data_o  out  DataWidth  voted word (registered)
valid_o  out  1  data_o valid
ready_i  in  1  downstream ready
mismatch_o  out  3  {C,B,A} disagreement flags for data_o beat
uncorrectable_o  out  1  data_o beat not trustworthy
state_o  out  2  0 TMR_OK, 1 DEGRADED, 2 FAIL
faulty_o  out  3  one-hot excluded replica (DEGRADED only), else 0
err_cnt_o  out  3*CntWidth  saturating mismatch counts; A in LSBs
clear_i  in  1  synchronous clear of state, faulty_o, counters

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: valid_o=0, data_o=0, mismatch_o=0, uncorrectable_o=0, state_o=0, faulty_o=0, all counters 0.
- Reset asserted mid-stream drops the in-flight beat.
- Handshake:
  - ready_o = ~valid_o | ready_i (combinational).
  - On accept, data_o, mismatch_o and uncorrectable_o load and valid_o=1, so latency is 1 cycle.
  - If valid_o & ready_i and no new accept, valid_o goes to 0.
  - Outputs are held stable while valid_o & ~ready_i.
  - Fault statistics update only on accepted beats.
- TMR_OK and FAIL voting:
  - voted = per-bit majority of a, b, c.
  - mismatch[k] = (replica_k != voted).
  - uncorrectable = 1 iff a, b and c are pairwise all different; in FAIL it is forced to 1.
- DEGRADED voting (replica k excluded):
  - Output is the lower-index active replica.
  - mismatch[k] = 0.
  - If the two active replicas differ, both active mismatch bits are 1 and uncorrectable = 1.
- Per-replica consecutive counter cons[k] (internal, saturates at FaultThreshold):
  - On an accepted beat, increments when mismatch[k] is set and clears otherwise.
  - Counts only in TMR_OK.
- Transitions (evaluated on accepted beat, next-state visible the following cycle):
  - TMR_OK -> DEGRADED when exactly one cons[k] reaches FaultThreshold on this beat; faulty_o = one-hot k.
  - TMR_OK -> FAIL when two or more reach it on the same beat, or when the beat is uncorrectable.
  - DEGRADED -> FAIL when the active pair differ.
  - FAIL is sticky.
- err_cnt[k]: +1 on each accepted beat with mismatch[k]=1 in any state; saturates at 2^CntWidth-1, no wrap.
- clear_i:
  - State returns to TMR_OK; faulty_o, cons and err_cnt go to 0.
  - Takes priority over any same-cycle statistics update.
  - A beat accepted in the same cycle still passes through the data path, but is not counted.
  - Does not touch valid_o or data_o.

Decomposition:
- Package tmr_word_voter_pkg: state_e enum (TMR_OK=2'd0, DEGRADED=2'd1, FAIL=2'd2) and VoterType encoding constants.
- Sub-module tmr_word_vote (combinational): per-bit majority using the VoterType structure, producing the voted word, the 3-bit mismatch vector and the all-differ flag.
- Degraded muxing, counters and FSM live in the top.

Test Plan:
All scenarios use DataWidth=8, FaultThreshold=3, CntWidth=2, ready_i=1 unless stated.
- a=b=c=0xA5, one beat -> next cycle valid_o=1, data_o=0xA5, mismatch_o=000, uncorrectable_o=0, state_o=0.
- a=b=0xA5, c=0xA4 for 3 beats -> data_o=0xA5 each beat, mismatch_o=100; after 3rd beat state_o=1, faulty_o=100, C counter=3; a 4th wrong beat leaves C counter at 3 (saturated).
- While DEGRADED on C: a=0x11, b=0x22, c=0x33 -> data_o=0x11, mismatch_o=011, uncorrectable_o=1, state_o=2; later a=b=c=0x00 still gives uncorrectable_o=1.
- ready_i=0 with valid_o=1 -> ready_o=0; data_o and flags held; a replica mismatch presented on the input does not change any counter.
- c wrong on 2 beats, correct on 1 beat, wrong on 2 beats -> state_o stays 0 (cons reset); C counter=3.
- clear_i in the same cycle as an accepted mismatching beat -> data passes, all counters 0, state_o=0. Separately, assert rst_i mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tmr_word_voter_pkg.sv
// tmr_word_voter_pkg: monitor states and voter structure encodings shared by the TMR word voter.
package tmr_word_voter_pkg;
  typedef enum logic [1:0] {
    TMR_OK   = 2'd0,
    DEGRADED = 2'd1,
    FAIL     = 2'd2
  } state_e;
  localparam int VOTER_AND_OR = 0;
  localparam int VOTER_KP     = 1;
  localparam int VOTER_BN     = 2;
endpackage

// File: rtl/tmr_word_vote.sv
// tmr_word_vote: per-bit majority of three replica words, with disagreement and all-differ flags.
module tmr_word_vote
  import tmr_word_voter_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int VoterType = VOTER_BN
) (
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [DataWidth-1:0] c_i,
  output logic [DataWidth-1:0] voted_o,
  output logic [2:0]           mismatch_o,
  output logic                 all_differ_o
);
  if (VoterType < VOTER_AND_OR || VoterType > VOTER_BN) begin : g_bad
    $fatal(1, "tmr_word_vote: unsupported VoterType %0d", VoterType);
  end
  for (genvar i = 0; i < DataWidth; i++) begin : g_bit
    if (VoterType == VOTER_AND_OR) begin : g_ao
      assign voted_o[i] = (a_i[i] & b_i[i]) | (a_i[i] & c_i[i]) | (b_i[i] & c_i[i]);
    end else if (VoterType == VOTER_KP) begin : g_kp
      assign voted_o[i] = (a_i[i] ^ b_i[i]) ? c_i[i] : a_i[i];
    end else begin : g_bn
      assign voted_o[i] = (b_i[i] ^ c_i[i]) ? a_i[i] : b_i[i];
    end
  end
  assign mismatch_o   = {c_i != voted_o, b_i != voted_o, a_i != voted_o};
  assign all_differ_o = (a_i != b_i) && (b_i != c_i) && (a_i != c_i);
endmodule

// File: rtl/tmr_word_voter_monitor.sv
// tmr_word_voter_monitor: registered TMR word voter with per-replica fault tracking,
// degraded-mode exclusion of a persistently wrong replica and sticky failure detection.
module tmr_word_voter_monitor
  import tmr_word_voter_pkg::*;
#(
  parameter int DataWidth      = 32,
  parameter int VoterType      = VOTER_BN,
  parameter int FaultThreshold = 4,
  parameter int CntWidth       = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DataWidth-1:0]  a_i,
  input  logic [DataWidth-1:0]  b_i,
  input  logic [DataWidth-1:0]  c_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DataWidth-1:0]  data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [2:0]            mismatch_o,
  output logic                  uncorrectable_o,
  output logic [1:0]            state_o,
  output logic [2:0]            faulty_o,
  output logic [3*CntWidth-1:0] err_cnt_o,
  input  logic                  clear_i
);
  localparam int ConsW = $clog2(FaultThreshold + 1);
  state_e               r_state, w_state_nxt;
  logic [2:0]           r_faulty, w_faulty_nxt;
  logic                 r_valid, r_unc;
  logic [DataWidth-1:0] r_data;
  logic [2:0]           r_mm;
  logic [DataWidth-1:0] w_vote, w_x, w_y, w_data;
  logic [2:0]           w_mm_tmr, w_mm, w_hit;
  logic                 w_all_diff, w_pair_diff, w_unc, w_acc, w_deg;

  tmr_word_vote #(.DataWidth(DataWidth), .VoterType(VoterType)) u_vote (
    .a_i          (a_i),
    .b_i          (b_i),
    .c_i          (c_i),
    .voted_o      (w_vote),
    .mismatch_o   (w_mm_tmr),
    .all_differ_o (w_all_diff)
  );

  assign ready_o = ~r_valid | ready_i;
  assign w_acc   = valid_i & ready_o;
  assign w_deg   = r_state == DEGRADED;
  // Active pair in degraded mode: w_x is the lower-index survivor, w_y the other one
  assign w_x         = r_faulty[0] ? b_i : a_i;
  assign w_y         = r_faulty[2] ? b_i : c_i;
  assign w_pair_diff = w_x != w_y;
  assign w_data      = w_deg ? w_x : w_vote;
  assign w_mm        = w_deg ? (w_pair_diff ? ~r_faulty : 3'b000) : w_mm_tmr;
  assign w_unc       = w_deg ? w_pair_diff : (w_all_diff | (r_state == FAIL));

  for (genvar k = 0; k < 3; k++) begin : g_rep
    logic [ConsW-1:0]    r_cons, w_cons_nxt;
    logic [CntWidth-1:0] r_cnt;
    assign w_cons_nxt = !w_mm[k] ? '0 :
                        (r_cons == ConsW'(FaultThreshold)) ? r_cons : r_cons + 1'b1;
    assign w_hit[k]   = w_mm[k] && (w_cons_nxt == ConsW'(FaultThreshold));
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
        r_cons <= '0;
        r_cnt  <= '0;
      end else if (clear_i) begin
        r_cons <= '0;
        r_cnt  <= '0;
      end else if (w_acc) begin
        if (r_state == TMR_OK) r_cons <= w_cons_nxt;
        if (w_mm[k] && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    assign err_cnt_o[k*CntWidth +: CntWidth] = r_cnt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_faulty_nxt = r_faulty;
    if (clear_i) begin
      w_state_nxt  = TMR_OK;
      w_faulty_nxt = '0;
    end else if (w_acc && r_state == TMR_OK) begin
      if (w_all_diff || $countones(w_hit) > 1) w_state_nxt = FAIL;
      else if (w_hit != '0) begin
        w_state_nxt  = DEGRADED;
        w_faulty_nxt = w_hit;
      end
    end else if (w_acc && w_deg && w_pair_diff) w_state_nxt = FAIL;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state  <= TMR_OK;
      r_faulty <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_faulty <= w_faulty_nxt;
    end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mm    <= '0;
      r_unc   <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_mm    <= w_mm;
      r_unc   <= w_unc;
    end else if (ready_i) r_valid <= 1'b0;

  assign valid_o         = r_valid;
  assign data_o          = r_data;
  assign mismatch_o      = r_mm;
  assign uncorrectable_o = r_unc;
  assign state_o         = r_state;
  assign faulty_o        = w_deg ? r_faulty : 3'b000;
endmodule
